// File: rtl/coeff_token_nc_decode_if.sv
// +----------------------------------------------------------------------------+
// | coeff_token_nc_decode_if                                                   |
// | Picture control, bitstream/ROM and result handshakes of the decoder.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface coeff_token_nc_decode_if #(
    parameter int W_MB = 8
);
    logic            Start;
    logic [W_MB-1:0] PicWidthMbs;
    logic [W_MB-1:0] PicHeightMbs;
    logic [15:0]     BitstreamShifted;
    logic            InValid;
    logic            InReady;
    logic            MbSkip;
    logic [1:0]      TableSel;
    logic [4:0]      RomTotalCoeff;
    logic [1:0]      RomTrailingOnes;
    logic [4:0]      RomNumShift;
    logic [4:0]      TotalCoeff;
    logic [1:0]      TrailingOnes;
    logic [4:0]      NumShift;
    logic [5:0]      NC;
    logic            OutValid;
    logic            OutReady;
    logic            PicDone;

    // master: shifter/ROM/downstream environment; slave: the decoder
    modport master (
        output Start, PicWidthMbs, PicHeightMbs, BitstreamShifted, InValid, MbSkip,
               RomTotalCoeff, RomTrailingOnes, RomNumShift, OutReady,
        input  InReady, TableSel, TotalCoeff, TrailingOnes, NumShift, NC, OutValid, PicDone
    );

    modport slave (
        input  Start, PicWidthMbs, PicHeightMbs, BitstreamShifted, InValid, MbSkip,
               RomTotalCoeff, RomTrailingOnes, RomNumShift, OutReady,
        output InReady, TableSel, TotalCoeff, TrailingOnes, NumShift, NC, OutValid, PicDone
    );
endinterface

`default_nettype wire

// File: rtl/coeff_token_nc_decode.sv
// +----------------------------------------------------------------------------+
// | coeff_token_nc_decode                                                      |
// | Luma 4x4 coeff_token decoder with neighbour-based nC prediction.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module coeff_token_nc_decode #(
    parameter int MB_WIDTH_MAX = 120,
    parameter int W_MB         = 8
) (
    input  wire logic              Clk,
    input  wire logic              nReset,
    coeff_token_nc_decode_if.slave bus
);

    localparam int TW = $clog2(4 * MB_WIDTH_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NC   = 2'd1,
        S_RDY  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t          rState, wNextState;
    logic [3:0]      rBlk;
    logic [W_MB-1:0] rMbx, rMby, rPicW, rPicH;
    logic [4:0]      rLeftCol [4];
    logic [4:0]      rTopLine [4*MB_WIDTH_MAX];
    logic [5:0]      rNc;
    logic [1:0]      rTableSel;
    logic [4:0]      rTotalCoeff, rNumShift;
    logic [1:0]      rTrailingOnes;
    logic            rPicDone, rLastBlk;

    logic [1:0]      wBx, wBy;
    logic [TW-1:0]   wTopIdx;
    logic            wLastCol, wLastMb, wAvailA, wAvailB;
    logic [W_MB-1:0] wNextMbx, wNextMby;
    logic [4:0]      wNa, wNb;
    logic [5:0]      wSum, wNc;
    logic [1:0]      wTableSel;
    logic [5:0]      wFlcCode;
    logic [4:0]      wResTc, wResNs;
    logic [1:0]      wResT1;
    logic            wAccept, wSkip, wDone;

    assign wBx      = {rBlk[2], rBlk[0]};
    assign wBy      = {rBlk[3], rBlk[1]};
    assign wTopIdx  = TW'({rMbx, wBx});
    assign wLastCol = (rMbx == rPicW - W_MB'(1));
    assign wLastMb  = wLastCol && (rMby == rPicH - W_MB'(1));
    assign wAvailA  = (rMbx != '0) || (wBx != 2'd0);
    assign wAvailB  = (rMby != '0) || (wBy != 2'd0);

    always_comb begin
        wNextMbx = rMbx + W_MB'(1);
        wNextMby = rMby;
        if (wLastCol) begin
            wNextMbx = '0;
            wNextMby = rMby + W_MB'(1);
        end
    end

    // nC context from left/top neighbours and the VLC table it selects
    always_comb begin
        wNa  = rLeftCol[wBy];
        wNb  = rTopLine[wTopIdx];
        wSum = {1'b0, wNa} + {1'b0, wNb} + 6'd1;
        wNc  = 6'd0;
        if (wAvailA && wAvailB) wNc = {1'b0, wSum[5:1]};
        else if (wAvailA)       wNc = {1'b0, wNa};
        else if (wAvailB)       wNc = {1'b0, wNb};
        if (wNc < 6'd2)      wTableSel = 2'd0;
        else if (wNc < 6'd4) wTableSel = 2'd1;
        else if (wNc < 6'd8) wTableSel = 2'd2;
        else                 wTableSel = 2'd3;
    end

    // Token result: ROM for the VLC tables, 6-bit fixed-length code for nC>=8
    always_comb begin
        wFlcCode = bus.BitstreamShifted[15:10];
        wResTc   = bus.RomTotalCoeff;
        wResT1   = bus.RomTrailingOnes;
        wResNs   = bus.RomNumShift;
        if (rTableSel == 2'd3) begin
            wResNs = 5'd6;
            if (wFlcCode == 6'b000011) begin
                wResTc = 5'd0;
                wResT1 = 2'd0;
            end else begin
                wResTc = {1'b0, wFlcCode[5:2]} + 5'd1;
                wResT1 = wFlcCode[1:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) rState <= S_IDLE;
        else         rState <= wNextState;
    end

    always_comb begin
        wNextState = rState;
        wAccept    = 1'b0;
        wSkip      = 1'b0;
        wDone      = 1'b0;
        if (bus.Start) begin
            wNextState = S_NC;
        end else begin
            case (rState)
                S_IDLE: wNextState = S_IDLE;
                S_NC:   wNextState = S_RDY;
                S_RDY: begin
                    if (bus.InValid) begin
                        wAccept    = 1'b1;
                        wNextState = S_OUT;
                    end else if (bus.MbSkip && (rBlk == 4'd0)) begin
                        wSkip      = 1'b1;
                        wDone      = wLastMb;
                        wNextState = wLastMb ? S_IDLE : S_NC;
                    end
                end
                S_OUT: begin
                    if (bus.OutReady) begin
                        wDone      = rLastBlk;
                        wNextState = rLastBlk ? S_IDLE : S_NC;
                    end
                end
                default: wNextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            rBlk          <= '0;
            rMbx          <= '0;
            rMby          <= '0;
            rPicW         <= '0;
            rPicH         <= '0;
            rNc           <= '0;
            rTableSel     <= '0;
            rTotalCoeff   <= '0;
            rTrailingOnes <= '0;
            rNumShift     <= '0;
            rPicDone      <= 1'b0;
            rLastBlk      <= 1'b0;
            for (int i = 0; i < 4; i++) rLeftCol[i] <= '0;
            for (int i = 0; i < 4*MB_WIDTH_MAX; i++) rTopLine[i] <= '0;
        end else begin
            rPicDone <= wDone;
            if (bus.Start) begin
                rBlk  <= '0;
                rMbx  <= '0;
                rMby  <= '0;
                rPicW <= bus.PicWidthMbs;
                rPicH <= bus.PicHeightMbs;
            end else begin
                if (rState == S_NC) begin
                    rNc       <= wNc;
                    rTableSel <= wTableSel;
                end
                if (wAccept) begin
                    rTotalCoeff        <= wResTc;
                    rTrailingOnes      <= wResT1;
                    rNumShift          <= wResNs;
                    rLeftCol[wBy]      <= wResTc;
                    rTopLine[wTopIdx]  <= wResTc;
                    rBlk               <= rBlk + 4'd1;
                    rLastBlk           <= (rBlk == 4'd15) && wLastMb;
                    if (rBlk == 4'd15) begin
                        rMbx <= wNextMbx;
                        rMby <= wNextMby;
                    end
                end
                if (wSkip) begin
                    for (int j = 0; j < 4; j++) begin
                        rLeftCol[j]                   <= '0;
                        rTopLine[TW'({rMbx, 2'(j)})] <= '0;
                    end
                    rMbx <= wNextMbx;
                    rMby <= wNextMby;
                end
            end
        end
    end

    assign bus.InReady      = (rState == S_RDY) && !bus.Start;
    assign bus.OutValid     = (rState == S_OUT);
    assign bus.TableSel     = rTableSel;
    assign bus.NC           = rNc;
    assign bus.TotalCoeff   = rTotalCoeff;
    assign bus.TrailingOnes = rTrailingOnes;
    assign bus.NumShift     = rNumShift;
    assign bus.PicDone      = rPicDone;

endmodule

`default_nettype wire

// File: tb/tb_coeff_token_nc_decode.sv
// +----------------------------------------------------------------------------+
// | tb_coeff_token_nc_decode                                                   |
// | Directed self-checking bench for coeff_token_nc_decode.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_coeff_token_nc_decode;

    logic Clk;
    logic nReset;
    int   nAsserts;
    int   nFail;

    coeff_token_nc_decode_if #(.W_MB(8)) bus ();

    coeff_token_nc_decode #(
        .MB_WIDTH_MAX(120),
        .W_MB        (8)
    ) dut (
        .Clk   (Clk),
        .nReset(nReset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic startPic(input logic [7:0] w, input logic [7:0] h);
        bus.PicWidthMbs  = w;
        bus.PicHeightMbs = h;
        bus.Start        = 1'b1;
        tick();
        bus.Start        = 1'b0;
    endtask

    task automatic waitRdy();
        int n;
        n = 0;
        while (!bus.InReady && n < 20) begin
            tick();
            n++;
        end
        check("wait_inready", bus.InReady, 1);
    endtask

    task automatic sendToken(input logic [4:0] tc, input logic [1:0] t1,
                             input logic [4:0] ns, input logic [15:0] bits);
        bus.InValid          = 1'b1;
        bus.RomTotalCoeff    = tc;
        bus.RomTrailingOnes  = t1;
        bus.RomNumShift      = ns;
        bus.BitstreamShifted = bits;
        tick();
        bus.InValid          = 1'b0;
    endtask

    task automatic releaseOut();
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
    endtask

    initial begin
        nAsserts = 0;
        nFail    = 0;
        nReset   = 1'b0;
        bus.Start = 1'b0;
        bus.PicWidthMbs = '0;
        bus.PicHeightMbs = '0;
        bus.BitstreamShifted = '0;
        bus.InValid = 1'b0;
        bus.MbSkip = 1'b0;
        bus.RomTotalCoeff = '0;
        bus.RomTrailingOnes = '0;
        bus.RomNumShift = '0;
        bus.OutReady = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_inready", bus.InReady, 0);
        check("rst_tablesel", bus.TableSel, 0);
        check("rst_nc", bus.NC, 0);
        check("rst_picdone", bus.PicDone, 0);
        check("rst_totalcoeff", bus.TotalCoeff, 0);
        nReset = 1'b1;
        tick();
        check("idle_inready", bus.InReady, 0);

        // First block: no neighbours, ROM result passes through
        startPic(8'd2, 8'd1);
        waitRdy();
        check("first_nc", bus.NC, 0);
        check("first_tablesel", bus.TableSel, 0);
        sendToken(5'd3, 2'd2, 5'd5, 16'h0000);
        check("first_outvalid", bus.OutValid, 1);
        check("first_tc", bus.TotalCoeff, 3);
        check("first_t1", bus.TrailingOnes, 2);
        check("first_ns", bus.NumShift, 5);
        check("first_inready_busy", bus.InReady, 0);
        releaseOut();

        // Neighbour averaging and FLC within MB 0
        startPic(8'd2, 8'd1);
        waitRdy();
        sendToken(5'd4, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("blk1_nc", bus.NC, 4);
        check("blk1_tablesel", bus.TableSel, 2);
        sendToken(5'd6, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("blk2_nc", bus.NC, 4);
        sendToken(5'd2, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("blk3_nc", bus.NC, 4);
        check("blk3_tablesel", bus.TableSel, 2);
        sendToken(5'd9, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("blk4_nc", bus.NC, 6);
        sendToken(5'd8, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("blk5_nc", bus.NC, 8);
        check("blk5_tablesel", bus.TableSel, 3);
        sendToken(5'd31, 2'd3, 5'd1, {6'b000011, 10'h3ff});
        check("flc_zero_tc", bus.TotalCoeff, 0);
        check("flc_zero_t1", bus.TrailingOnes, 0);
        check("flc_zero_ns", bus.NumShift, 6);
        releaseOut();
        waitRdy();
        check("blk6_nc", bus.NC, 9);
        check("blk6_tablesel", bus.TableSel, 3);
        sendToken(5'd31, 2'd3, 5'd1, {6'b101110, 10'h155});
        check("flc_tc", bus.TotalCoeff, 12);
        check("flc_t1", bus.TrailingOnes, 2);
        check("flc_ns", bus.NumShift, 6);
        releaseOut();
        waitRdy();
        check("blk7_nc", bus.NC, 6);
        check("blk7_tablesel", bus.TableSel, 2);
        bus.MbSkip = 1'b1;
        tick();
        bus.MbSkip = 1'b0;
        check("skip_ignored_inready", bus.InReady, 1);
        check("skip_ignored_outvalid", bus.OutValid, 0);

        // MB row wrap over a 2x2 picture
        startPic(8'd2, 8'd2);
        for (int mb = 0; mb < 4; mb++) begin
            for (int b = 0; b < 16; b++) begin
                waitRdy();
                if (mb == 1 && b == 0) check("mb1_left_nc", bus.NC, 1);
                if (mb == 2 && b == 0) begin
                    check("row_wrap_nc", bus.NC, 5);
                    check("row_wrap_tablesel", bus.TableSel, 2);
                end
                sendToken((mb == 0 && b == 10) ? 5'd5 : 5'd1, 2'd0, 5'd2, 16'h0000);
                releaseOut();
            end
        end
        check("wrap_picdone", bus.PicDone, 1);
        check("wrap_idle_inready", bus.InReady, 0);
        tick();
        check("wrap_picdone_drop", bus.PicDone, 0);

        // MbSkip on the last MB ends the picture
        startPic(8'd2, 8'd1);
        for (int b = 0; b < 16; b++) begin
            waitRdy();
            sendToken(5'd3, 2'd1, 5'd4, 16'h0000);
            releaseOut();
        end
        waitRdy();
        bus.MbSkip = 1'b1;
        tick();
        bus.MbSkip = 1'b0;
        check("skip_picdone", bus.PicDone, 1);
        check("skip_outvalid", bus.OutValid, 0);
        check("skip_inready", bus.InReady, 0);
        tick();
        check("skip_picdone_drop", bus.PicDone, 0);
        startPic(8'd2, 8'd1);
        waitRdy();
        check("restart_nc", bus.NC, 0);

        // Backpressure then abort with Start
        sendToken(5'd7, 2'd0, 5'd3, 16'h0000);
        releaseOut();
        waitRdy();
        check("bp_nc", bus.NC, 7);
        sendToken(5'd2, 2'd1, 5'd3, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            check("bp_outvalid", bus.OutValid, 1);
            check("bp_tc", bus.TotalCoeff, 2);
            check("bp_t1", bus.TrailingOnes, 1);
            check("bp_ns", bus.NumShift, 3);
            check("bp_nc_hold", bus.NC, 7);
            check("bp_inready", bus.InReady, 0);
            tick();
        end
        startPic(8'd2, 8'd1);
        check("abort_outvalid", bus.OutValid, 0);
        check("abort_inready", bus.InReady, 0);
        tick();
        check("abort_rdy", bus.InReady, 1);
        check("abort_nc", bus.NC, 0);
        check("abort_tablesel", bus.TableSel, 0);

        // Asynchronous reset mid-picture
        sendToken(5'd9, 2'd0, 5'd3, 16'h0000);
        check("pre_rst_tc", bus.TotalCoeff, 9);
        #2;
        nReset = 1'b0;
        #1;
        check("async_rst_outvalid", bus.OutValid, 0);
        check("async_rst_tc", bus.TotalCoeff, 0);
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        check("post_rst_inready", bus.InReady, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

`default_nettype wire
